// File: rtl/lc3_mmio_pkg.sv
// Shared definitions for the LC-3 memory/IO controller: device map, FSM states,
// interrupt encodings and the address decoder.
package lc3_mmio_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    localparam logic [7:0] INTV_KBD  = 8'h80;
    localparam logic [7:0] INTV_DISP = 8'h81;
    localparam logic [2:0] INTP_DEV  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} memState_t;

    typedef enum logic [2:0] {
        SEL_SRAM, SEL_KBSR, SEL_KBDR, SEL_DSR, SEL_DDR, SEL_MCR, SEL_NONE
    } devSel_t;

    // 0xFE00..0xFFFF is the device page; unlisted addresses there are unmapped.
    function automatic devSel_t decodeAddr(input logic [15:0] addr);
        devSel_t sel;
        sel = SEL_SRAM;
        if (addr[15:9] == 7'b1111111) begin
            case (addr)
                ADDR_KBSR: sel = SEL_KBSR;
                ADDR_KBDR: sel = SEL_KBDR;
                ADDR_DSR:  sel = SEL_DSR;
                ADDR_DDR:  sel = SEL_DDR;
                ADDR_MCR:  sel = SEL_MCR;
                default:   sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Device registers (KBSR/KBDR/DSR/DDR/MCR), keyboard/display handshakes and
// interrupt request encoding.
module lc3_mmio_regs
    import lc3_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  devSel_t     regSel,
    input  logic        regWe,
    input  logic [15:0] regWdata,
    input  logic        commit,
    output logic [15:0] regRdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic [15:0] MCR,
    output logic        IRQ,
    output logic [7:0]  INTV,
    output logic [2:0]  INTP
);

    logic        kbsrReady;
    logic        kbsrIe;
    logic [7:0]  kbdrChar;
    logic        dsrIe;
    logic        dispValidReg;
    logic [7:0]  dispDataReg;
    logic [15:0] mcrReg;
    logic        dispFree;

    // A handshake in the same cycle frees the slot before a DDR write lands.
    assign dispFree = !dispValidReg || disp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            kbsrReady    <= 1'b0;
            kbsrIe       <= 1'b0;
            kbdrChar     <= 8'h00;
            dsrIe        <= 1'b0;
            dispValidReg <= 1'b0;
            dispDataReg  <= 8'h00;
            mcrReg       <= 16'h8000;
        end else begin
            if (kbd_valid && !kbsrReady) begin
                kbsrReady <= 1'b1;
                kbdrChar  <= kbd_data;
            end
            if (dispValidReg && disp_ready) begin
                dispValidReg <= 1'b0;
            end
            if (commit) begin
                if (regWe) begin
                    case (regSel)
                        SEL_KBSR: kbsrIe <= regWdata[14];
                        SEL_DSR:  dsrIe  <= regWdata[14];
                        SEL_DDR: begin
                            if (dispFree) begin
                                dispDataReg  <= regWdata[7:0];
                                dispValidReg <= 1'b1;
                            end
                        end
                        SEL_MCR:  mcrReg <= regWdata;
                        default:  ;
                    endcase
                end else if (regSel == SEL_KBDR) begin
                    kbsrReady <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regRdata = 16'h0000;
        case (regSel)
            SEL_KBSR: regRdata = {kbsrReady, kbsrIe, 14'h0000};
            SEL_KBDR: regRdata = {8'h00, kbdrChar};
            SEL_DSR:  regRdata = {!dispValidReg, dsrIe, 14'h0000};
            SEL_DDR:  regRdata = {8'h00, dispDataReg};
            SEL_MCR:  regRdata = mcrReg;
            default:  regRdata = 16'h0000;
        endcase
    end

    always_comb begin
        IRQ  = 1'b0;
        INTV = 8'h00;
        INTP = 3'd0;
        if (kbsrReady && kbsrIe) begin
            IRQ  = 1'b1;
            INTV = INTV_KBD;
            INTP = INTP_DEV;
        end else if (!dispValidReg && dsrIe) begin
            IRQ  = 1'b1;
            INTV = INTV_DISP;
            INTP = INTP_DEV;
        end
    end

    assign kbd_ready  = !kbsrReady;
    assign disp_valid = dispValidReg;
    assign disp_data  = dispDataReg;
    assign MCR        = mcrReg;

endmodule

// File: rtl/lc3_memctrl.sv
// LC-3 memory port controller: decodes requests, sequences SRAM accesses with
// programmable wait states, and hands device accesses to lc3_mmio_regs.
module lc3_memctrl
    import lc3_mmio_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_din,
    output logic [15:0] mem_dout,
    output logic        mem_rdy,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic [15:0] MCR,
    output logic        IRQ,
    output logic [7:0]  INTV,
    output logic [2:0]  INTP
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    memState_t   stateReg, stateNext;
    logic [3:0]  cntReg, cntNext;
    logic [15:0] addrReg;
    logic [15:0] dinReg;
    logic        weReg;
    devSel_t     selReg;
    devSel_t     reqSel;
    logic        ramStrobe;
    logic        regCommit;
    logic [15:0] regRdata;

    assign reqSel = decodeAddr(mem_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            cntReg   <= 4'd0;
            addrReg  <= 16'h0000;
            dinReg   <= 16'h0000;
            weReg    <= 1'b0;
            selReg   <= SEL_SRAM;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (stateReg == ST_IDLE && mem_en) begin
                addrReg <= mem_addr;
                dinReg  <= mem_din;
                weReg   <= mem_we;
                selReg  <= reqSel;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        ramStrobe = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (mem_en) begin
                    stateNext = ST_ACCESS;
                    cntNext   = (reqSel == SEL_SRAM) ? WAIT_CNT : 4'd0;
                end
            end
            ST_ACCESS: begin
                if (cntReg != 4'd0) begin
                    cntNext = cntReg - 4'd1;
                end else begin
                    stateNext = ST_RESP;
                    ramStrobe = (selReg == SEL_SRAM);
                end
            end
            ST_RESP:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // SRAM outputs are held at zero outside the strobe cycle.
    assign ram_en    = ramStrobe;
    assign ram_we    = ramStrobe && weReg;
    assign ram_addr  = ramStrobe ? addrReg : 16'h0000;
    assign ram_wdata = ramStrobe ? dinReg : 16'h0000;

    assign mem_rdy   = (stateReg == ST_RESP);
    assign regCommit = mem_rdy && (selReg != SEL_SRAM);

    always_comb begin
        mem_dout = 16'h0000;
        if (mem_rdy && !weReg) begin
            mem_dout = (selReg == SEL_SRAM) ? ram_rdata : regRdata;
        end
    end

    lc3_mmio_regs uRegs (
        .clk        (clk),
        .rst        (rst),
        .regSel     (selReg),
        .regWe      (weReg),
        .regWdata   (dinReg),
        .commit     (regCommit),
        .regRdata   (regRdata),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .MCR        (MCR),
        .IRQ        (IRQ),
        .INTV       (INTV),
        .INTP       (INTP)
    );

endmodule

// File: doc/lc3_memctrl.md
# lc3_memctrl

Memory/I-O controller sitting directly downstream of the LC-3 core's memory port. Accepts the core's enable/write-enable/address/data request, services it from external synchronous SRAM (with programmable wait states) or from the memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR), and returns a one-cycle ready pulse with read data. Also owns the keyboard/display handshakes, drives the MCR word back to the core, and generates the core's IRQ/INTV/INTP interrupt inputs.

## Interface
- WAIT_STATES, 0, extra ACCESS cycles for SRAM accesses (0..15).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  access request from core; held with addr/din/we until mem_rdy.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  16  word address.
- mem_din  in  16  write data from core.
- mem_dout  out  16  read data; valid only with mem_rdy.
- mem_rdy  out  1  one-cycle completion pulse.
- ram_en / ram_we  out  1 / 1  SRAM strobe and write enable (one cycle per access).
- ram_addr / ram_wdata  out  16 / 16  SRAM address and write data.
- ram_rdata  in  16  SRAM read data, valid the cycle after ram_en.
- kbd_valid / kbd_data  in  1 / 8  keyboard character offer.
- kbd_ready  out  1  = ~KBSR[15]; character accepted when kbd_valid & kbd_ready.
- disp_valid / disp_data  out  1 / 8  display character offer, held until disp_ready.
- disp_ready  in  1  display consumes character when disp_valid & disp_ready.
- MCR  out  16  machine control register (bit 15 = clock enable).
- IRQ / INTV / INTP  out  1 / 8 / 3  interrupt request, vector, priority.

## Operation
- Decode: 0xFE00 KBSR, 0xFE02 KBDR, 0xFE04 DSR, 0xFE06 DDR, 0xFFFE MCR; other 0xFE00–0xFFFF unmapped (read 0x0000, write ignored, still completes); everything else SRAM.
- FSM: IDLE → ACCESS → RESP → IDLE.
  - IDLE: mem_en=1 latches addr/din/we/decode; cnt ← WAIT_STATES (SRAM) or 0 (device); → ACCESS.
  - ACCESS: cnt≠0 → decrement, stay. cnt=0 → SRAM: ram_en=1, ram_we=latched we, ram_addr/ram_wdata=latched; → RESP.
  - RESP: mem_rdy=1; read: mem_dout = ram_rdata (SRAM) or register value (device); write: mem_dout=0x0000. Device writes and KBDR read side-effect commit at the edge ending RESP. → IDLE.
- mem_en still high in IDLE after RESP is a new access (back-to-back legal). mem_en changes outside IDLE are ignored.
- KBSR: [15] ready (set on keyboard accept, cleared on KBDR read), [14] IE (writable), others read 0. KBDR: {8'h00, char}.
- DSR: [15] ready = ~disp_valid, [14] IE (writable). DDR write: if disp_valid=0, disp_data←din[7:0], disp_valid←1; if disp_valid=1, write dropped. DDR read returns {8'h00, disp_data}.
- MCR: all 16 bits writable.
- Interrupts (combinational from registers): kbd pending = KBSR[15]&KBSR[14] → IRQ=1, INTV=0x80, INTP=4; else display pending = DSR[15]&DSR[14] → IRQ=1, INTV=0x81, INTP=4; else IRQ=0, INTV=0x00, INTP=0. Keyboard wins ties.

## Timing
- Request seen in IDLE at cycle 0 → SRAM: ram_en in cycle 1+WAIT_STATES, mem_rdy in cycle 2+WAIT_STATES; device: mem_rdy in cycle 2.
- mem_rdy high exactly one cycle; mem_dout=0x0000 whenever mem_rdy=0.
- Keyboard accept and KBDR-read clear cannot collide (kbd_ready=0 while KBSR[15]=1); new char accepted the cycle after the clear.
- DDR write in same cycle as disp_ready handshake: handshake completes first, so the write is accepted (disp_valid stays 1, new data).
- Reset values: FSM IDLE, mem_rdy 0, mem_dout 0, ram_en/ram_we 0, ram_addr/ram_wdata 0, KBSR 0x0000, KBDR 0x0000, disp_valid 0, disp_data 0, DSR reads 0x8000, kbd_ready 1, MCR 0x8000, IRQ 0, INTV 0x00, INTP 0.
- Reset mid-access: access abandoned, no mem_rdy, no register commit; pending display character dropped.

## Structure
- Package lc3_mmio_pkg: device address constants, FSM state enum, interrupt vector/priority constants (0x80, 0x81, 4).
- Sub-module lc3_mmio_regs: KBSR/KBDR/DSR/DDR/MCR, keyboard/display handshakes, interrupt encoding; top holds decode, FSM, wait counter, SRAM strobes.

## Test plan
- WAIT_STATES=2, SRAM write 0x1234 to 0x3000 then read → ram_en cycle 3, mem_rdy cycle 4 each; read returns 0x1234.
- kbd_valid with 0x41, KBSR IE=1 → KBSR reads 0xC000, IRQ=1/INTV=0x80/INTP=4; KBDR read returns 0x0041, KBSR then 0x4000, IRQ=0.
- DDR write 0x0058 with disp_ready=0 → DSR 0x0000; second DDR write 0x0059 dropped; disp_ready=1 → disp_data 0x58 consumed, DSR 0x8000.
- Keyboard and display both pending with IE set → INTV=0x80; read KBDR → INTV=0x81.
- MCR write 0x0000 → MCR output 0x0000; unmapped 0xFE10 read → 0x0000 with mem_rdy at cycle 2.
- rst asserted in ACCESS of a KBDR read → no mem_rdy, KBSR[15] still cleared only by reset (all outputs at reset values next cycle).
